// File: rtl/cpu_defs.sv
// Shared core definitions: register-file geometry and the register index type.
package cpu_defs;

  localparam int REG_ADDR_W = 5;
  localparam int NREG       = 32;
  localparam int DATA_W     = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage : cpu_defs

// File: rtl/regfile_2w4r_read_port.sv
// One combinational read port of the register file. It applies the
// zero-register rule and, when enabled, the same-cycle write bypass with the
// slave write taking priority over the master write.
module regfile_read_port
  import cpu_defs::reg_addr_t;
#(
  parameter int DATA_W       = cpu_defs::DATA_W,
  parameter int NREG         = cpu_defs::NREG,
  parameter bit WRITE_BYPASS = 1'b1
) (
  input  logic              resetn_i,
  input  logic [4:0]        raddr_i,
  input  logic [DATA_W-1:0] regs_i [NREG],
  input  logic              wen1_i,
  input  logic [4:0]        waddr1_i,
  input  logic [DATA_W-1:0] wdata1_i,
  input  logic              wen2_i,
  input  logic [4:0]        waddr2_i,
  input  logic [DATA_W-1:0] wdata2_i,
  output logic [DATA_W-1:0] rdata_o
);

  reg_addr_t raddr;
  assign raddr = raddr_i;

  // Select the operand: zero for r0 or while in reset, else bypass, else storage.
  always_comb begin
    // NOTE: the default assignment first guarantees every path drives rdata_o,
    // so no latch can be inferred from an incomplete if/else chain.
    rdata_o = '0;
    // Storage is already zero during reset; the resetn gate only stops a
    // pending write from leaking through the bypass while reset is held.
    if (resetn_i && (raddr != '0)) begin
      if (WRITE_BYPASS && wen2_i && (waddr2_i == raddr)) begin
        rdata_o = wdata2_i;
      end else if (WRITE_BYPASS && wen1_i && (waddr1_i == raddr)) begin
        rdata_o = wdata1_i;
      end else begin
        rdata_o = regs_i[raddr];
      end
    end
  end

endmodule : regfile_read_port

// File: rtl/regfile_2w4r.sv
// Dual-issue general-purpose register file: 32 x 32-bit, master and slave
// writeback ports, four combinational operand read ports. Register 0 is
// hardwired to zero; on a same-index double write the slave (younger) wins.
module regfile_2w4r
  import cpu_defs::reg_addr_t;
#(
  parameter int DATA_W       = cpu_defs::DATA_W,
  parameter int NREG         = cpu_defs::NREG,
  parameter bit WRITE_BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              wen1,
  input  logic [4:0]        waddr1,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              wen2,
  input  logic [4:0]        waddr2,
  input  logic [DATA_W-1:0] wdata2,
  input  logic [4:0]        master_rs,
  output logic [DATA_W-1:0] master_rs_value_tmp,
  input  logic [4:0]        master_rt,
  output logic [DATA_W-1:0] master_rt_value_tmp,
  input  logic [4:0]        slave_rs,
  output logic [DATA_W-1:0] slave_rs_value_tmp,
  input  logic [4:0]        slave_rt,
  output logic [DATA_W-1:0] slave_rt_value_tmp
);

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];

  // Next-state of every register: slave write checked first so it wins a conflict.
  always_comb begin
    regs_d    = regs_q;
    regs_d[0] = '0;
    for (int i = 1; i < NREG; i++) begin
      if (wen2 && (waddr2 == reg_addr_t'(i))) begin
        regs_d[i] = wdata2;
      end else if (wen1 && (waddr1 == reg_addr_t'(i))) begin
        regs_d[i] = wdata1;
      end
    end
  end

  // Register storage with asynchronous clear; an edge under reset drops any write.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      // NOTE: the whole array is reset here because software relies on every
      // architectural register reading zero after reset; this forces a
      // flop-based array rather than a RAM macro.
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignment keeps every read in this time step
      // seeing the pre-edge contents, which the combinational read ports need.
      regs_q <= regs_d;
    end
  end

  regfile_read_port #(
    .DATA_W(DATA_W), .NREG(NREG), .WRITE_BYPASS(WRITE_BYPASS)
  ) u_rd_master_rs (
    .resetn_i(resetn), .raddr_i(master_rs), .regs_i(regs_q),
    .wen1_i(wen1), .waddr1_i(waddr1), .wdata1_i(wdata1),
    .wen2_i(wen2), .waddr2_i(waddr2), .wdata2_i(wdata2),
    .rdata_o(master_rs_value_tmp)
  );

  regfile_read_port #(
    .DATA_W(DATA_W), .NREG(NREG), .WRITE_BYPASS(WRITE_BYPASS)
  ) u_rd_master_rt (
    .resetn_i(resetn), .raddr_i(master_rt), .regs_i(regs_q),
    .wen1_i(wen1), .waddr1_i(waddr1), .wdata1_i(wdata1),
    .wen2_i(wen2), .waddr2_i(waddr2), .wdata2_i(wdata2),
    .rdata_o(master_rt_value_tmp)
  );

  regfile_read_port #(
    .DATA_W(DATA_W), .NREG(NREG), .WRITE_BYPASS(WRITE_BYPASS)
  ) u_rd_slave_rs (
    .resetn_i(resetn), .raddr_i(slave_rs), .regs_i(regs_q),
    .wen1_i(wen1), .waddr1_i(waddr1), .wdata1_i(wdata1),
    .wen2_i(wen2), .waddr2_i(waddr2), .wdata2_i(wdata2),
    .rdata_o(slave_rs_value_tmp)
  );

  regfile_read_port #(
    .DATA_W(DATA_W), .NREG(NREG), .WRITE_BYPASS(WRITE_BYPASS)
  ) u_rd_slave_rt (
    .resetn_i(resetn), .raddr_i(slave_rt), .regs_i(regs_q),
    .wen1_i(wen1), .waddr1_i(waddr1), .wdata1_i(wdata1),
    .wen2_i(wen2), .waddr2_i(waddr2), .wdata2_i(wdata2),
    .rdata_o(slave_rt_value_tmp)
  );

endmodule : regfile_2w4r

// File: doc/regfile_2w4r.md
Name: regfile_2w4r

Overview:
- General-purpose register file for the dual-issue core: 32 x 32-bit, two write ports (master, slave), four asynchronous read ports.
- Sits in decode, directly upstream of the operand-forwarding stage.
- Its four read results are the raw operand values (master rs/rt, slave rs/rt) that forwarding may later override with in-flight results.
- Write ports are driven from writeback.

Parameters:
- DATA_W, 32, register width in bits
- NREG, 32, number of architectural registers; register 0 is hardwired zero
- WRITE_BYPASS, 1, 1 = a read of a register being written this cycle returns the new data combinationally; 0 = returns the stored (old) value

Ports:
- clk  in  1  core clock; all writes on rising edge
- resetn  in  1  asynchronous active-low reset
- wen1  in  1  master writeback enable
- waddr1  in  5  master writeback register index
- wdata1  in  DATA_W  master writeback data
- wen2  in  1  slave writeback enable
- waddr2  in  5  slave writeback register index
- wdata2  in  DATA_W  slave writeback data
- master_rs  in  5  read index, port A
- master_rs_value_tmp  out  DATA_W  read data, port A
- master_rt  in  5  read index, port B
- master_rt_value_tmp  out  DATA_W  read data, port B
- slave_rs  in  5  read index, port C
- slave_rs_value_tmp  out  DATA_W  read data, port C
- slave_rt  in  5  read index, port D
- slave_rt_value_tmp  out  DATA_W  read data, port D

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - resetn low asynchronously clears all registers 1..NREG-1 to 0.
  - Reset is held for its duration and released synchronously by the SoC.
  - Reset asserted mid-write: the write is lost and the register reads 0.
- Write:
  - On a rising clk edge with resetn high, regs[waddrN] <= wdataN for each N with wenN=1 and waddrN != 0.
  - Writes to index 0 are discarded.
- Write-write conflict (wen1 and wen2 both 1, waddr1 == waddr2 != 0):
  - The slave is the younger instruction in program order, so wdata2 is stored.
  - wdata1 is dropped; no error is flagged.
- Read:
  - Purely combinational; zero-cycle latency.
  - Index 0 always returns 0, regardless of writes or bypass.
- Bypass (WRITE_BYPASS=1):
  - For each read port with index r != 0:
    - If wen2 && waddr2 == r, return wdata2.
    - Else if wen1 && waddr1 == r, return wdata1.
    - Else return regs[r].
  - Priority matches the write-conflict rule, so the read value equals the value visible after the edge.
- Bypass (WRITE_BYPASS=0):
  - Reads return regs[r] only.
  - The new value is visible starting the cycle after the write edge.
- Reset state of read outputs: every read port returns 0 for any index while resetn is low and after reset until written.
- No handshakes or stalls: writeback never back-pressures. Disabled write ports (wenN=0) ignore address and data, including X.
- Independence: all four read ports may use the same index simultaneously and must return identical values.

Decomposition:
- Shared package (cpu_defs): REG_ADDR_W=5, NREG=32, DATA_W=32, and typedef reg_addr_t (logic [4:0]).
- One natural sub-module, regfile_read_port: a single read mux implementing the zero-register rule and bypass priority, instantiated four times.
- The storage array and write logic live in the top module.

Test Plan:
- Reset then read: assert resetn=0 mid-run after writing r5=0x1234; then read r5 on all four ports -> all return 0x00000000.
- Basic write/read, WRITE_BYPASS=0: wen1=1, waddr1=3, wdata1=0xDEADBEEF, and read r3 the same cycle -> 0 before the edge, 0xDEADBEEF the cycle after on all ports.
- Zero register: wen1=1, waddr1=0, wdata1=0xFFFFFFFF, and wen2=1, waddr2=0, wdata2=0x1 -> r0 reads 0 on every port, both the same cycle (bypass on) and afterwards.
- WAW conflict: wen1=wen2=1, waddr1=waddr2=7, wdata1=0x11111111, wdata2=0x22222222 -> r7 = 0x22222222 after the edge; with WRITE_BYPASS=1 the same-cycle read of r7 is also 0x22222222.
- Dual distinct writes plus bypass (WRITE_BYPASS=1): write r8=0xA5A5A5A5 (port 1) and r9=0x5A5A5A5A (port 2), with master_rs=8, master_rt=9, slave_rs=9, slave_rt=10 (r10 previously 0x77) -> outputs 0xA5A5A5A5, 0x5A5A5A5A, 0x5A5A5A5A, 0x00000077 in the same cycle.
- Random regression: 10k cycles of random writes/reads checked against a reference array model using the stated slave-wins and bypass rules, for both WRITE_BYPASS values.
